// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back controller:
// geometry constants, FSM state encoding and requester slot indices.
package rf_pkg;

  localparam int RF_NREGS = 16;
  localparam int RF_AW    = 4;
  localparam int RF_DW    = 32;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_LNK = 2;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter (module rr_arbiter). The grant is combinational
// from REQ and the pointer. When ADV is high the pointer moves to the
// slot just past the granted requester; otherwise it holds.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic [N-1:0] REQ,
  input  logic         ADV,
  output logic [N-1:0] GNT
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  int            idx;

  // Scan downward from the farthest slot so that the nearest requester
  // at or after the pointer is the one left in GNT.
  always_comb begin
    GNT = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (REQ[idx]) begin
        GNT      = '0;
        GNT[idx] = 1'b1;
      end
    end
  end

  // Advance the pointer past the winner on a completed transfer.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ptr_q <= '0;
    end else if (ADV) begin
      for (int k = 0; k < N; k++) begin
        if (GNT[k]) ptr_q <= PW'((k + 1) % N);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the 16 x 32 register file.
// Sweeps a clear across every register after reset, then shares the
// single write port among NREQ requesters using round-robin arbitration.
// It also keeps a per-register busy scoreboard for the issue stage.
// Build option: RFCTL_SCOREBOARD_EN builds the scoreboard. Without it,
// BUSY is tied to zero and reservations are accepted whenever the
// controller is running.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   RF_INIT | clear strobe sweeps registers 0..15, no grants
//   RF_RUN  | arbitrate writes, maintain the scoreboard
module regfile_wb_ctrl
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [NREQ-1:0]      REQ_VALID,
  input  logic [NREQ*AW-1:0]   REQ_ADDR,
  input  logic [NREQ*DW-1:0]   REQ_DATA,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic                 RSV_VALID,
  input  logic [AW-1:0]        RSV_ADDR,
  output logic                 RSV_READY,
  output logic [RF_NREGS-1:0]  BUSY,
  output logic                 RF_WEN_N,
  output logic [AW-1:0]        RF_WSEL,
  output logic [DW-1:0]        RF_WDATA,
  output logic                 RF_CEN_N,
  output logic [AW-1:0]        RF_CSEL,
  output logic                 INIT_DONE
);

  rf_state_e       state_q, state_d;
  logic [3:0]      clr_cnt;
  logic            sweep_done;
  logic            run;
  logic [NREQ-1:0] req_qual;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  assign run       = (state_q == RF_RUN);
  assign INIT_DONE = run;
  assign req_qual  = REQ_VALID & {NREQ{run}};
  assign xfer      = |(REQ_VALID & REQ_READY);

  rr_arbiter #(.N(NREQ)) u_arb (
    .CLK (CLK),
    .CLR (CLR),
    .REQ (req_qual),
    .ADV (xfer),
    .GNT (REQ_READY)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state_q <= RF_INIT;
    else      state_q <= state_d;
  end

  // FSM next state: leave INIT one cycle after the last clear strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RF_INIT: if (sweep_done) state_d = RF_RUN;
      RF_RUN:  state_d = RF_RUN;
    endcase
  end

  // Clear sweep; sweep_done marks that all 16 strobes have been issued,
  // since the 4-bit counter itself wraps back to 0.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      clr_cnt    <= '0;
      sweep_done <= 1'b0;
      RF_CEN_N   <= 1'b1;
      RF_CSEL    <= '0;
    end else if (!run && !sweep_done) begin
      RF_CEN_N <= 1'b0;
      RF_CSEL  <= AW'(clr_cnt);
      clr_cnt  <= clr_cnt + 4'd1;
      if (clr_cnt == 4'hF) sweep_done <= 1'b1;
    end else begin
      RF_CEN_N <= 1'b1;
    end
  end

  // Route the granted requester's address and data to the write stage.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (REQ_READY[i]) begin
        sel_addr = REQ_ADDR[i*AW +: AW];
        sel_data = REQ_DATA[i*DW +: DW];
      end
    end
  end

  // Write stage: one-cycle strobe after each handshake; select/data hold.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      RF_WEN_N <= 1'b1;
      RF_WSEL  <= '0;
      RF_WDATA <= '0;
    end else begin
      RF_WEN_N <= !xfer;
      if (xfer) begin
        RF_WSEL  <= sel_addr;
        RF_WDATA <= sel_data;
      end
    end
  end

`ifdef RFCTL_SCOREBOARD_EN
  logic [RF_NREGS-1:0] busy_q, busy_d;

  assign RSV_READY = run && !busy_q[RSV_ADDR];
  assign BUSY      = busy_q;

  // Write clears its register; an accepted reservation applied after it
  // so the set wins when both hit the same register.
  always_comb begin
    busy_d = busy_q;
    if (xfer)                   busy_d[sel_addr] = 1'b0;
    if (RSV_VALID && RSV_READY) busy_d[RSV_ADDR] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) busy_q <= '0;
    else      busy_q <= busy_d;
  end
`else
  logic unused_rsv;

  assign unused_rsv = ^{RSV_VALID, RSV_ADDR};
  assign RSV_READY  = INIT_DONE;
  assign BUSY       = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl. Each cycle the bench model
// predicts grants, reservation acceptance and BUSY, and pushes every
// predicted write onto a queue; the write strobe is popped and compared
// one cycle later.
module tb_regfile_wb_ctrl;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 32;
`ifdef RFCTL_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic                CLK;
  logic                CLR;
  logic [NREQ-1:0]     REQ_VALID;
  logic [NREQ*AW-1:0]  REQ_ADDR;
  logic [NREQ*DW-1:0]  REQ_DATA;
  logic [NREQ-1:0]     REQ_READY;
  logic                RSV_VALID;
  logic [AW-1:0]       RSV_ADDR;
  logic                RSV_READY;
  logic [15:0]         BUSY;
  logic                RF_WEN_N;
  logic [AW-1:0]       RF_WSEL;
  logic [DW-1:0]       RF_WDATA;
  logic                RF_CEN_N;
  logic [AW-1:0]       RF_CSEL;
  logic                INIT_DONE;

  int          n_checks = 0;
  int          n_pass   = 0;
  wr_t         exp_q[$];
  int          m_ptr    = 0;
  logic [15:0] m_busy   = '0;
  bit          m_run    = 1'b0;
  int          last_gnt = -1;

  regfile_wb_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .REQ_VALID (REQ_VALID),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .RSV_VALID (RSV_VALID),
    .RSV_ADDR  (RSV_ADDR),
    .RSV_READY (RSV_READY),
    .BUSY      (BUSY),
    .RF_WEN_N  (RF_WEN_N),
    .RF_WSEL   (RF_WSEL),
    .RF_WDATA  (RF_WDATA),
    .RF_CEN_N  (RF_CEN_N),
    .RF_CSEL   (RF_CSEL),
    .INIT_DONE (INIT_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ_ADDR[i*AW +: AW] = a;
    REQ_DATA[i*DW +: DW] = d;
  endtask

  // One cycle: compare at the negedge, update the model for the coming
  // posedge, then return 1 time unit after that posedge.
  task automatic tick();
    wr_t         e;
    logic [NREQ-1:0] g;
    logic        rr;
    int          gi;
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wen_strobe", 32'(RF_WEN_N), 32'd0);
      check("wsel", 32'(RF_WSEL), 32'(e.addr));
      check("wdata", RF_WDATA, e.data);
    end else begin
      check("wen_idle", 32'(RF_WEN_N), 32'd1);
    end
    g  = '0;
    gi = -1;
    if (m_run) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gi < 0 && REQ_VALID[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
      end
    end
    if (gi >= 0) g[gi] = 1'b1;
    rr = m_run && (!SB || !m_busy[RSV_ADDR]);
    check("req_ready", 32'(REQ_READY), 32'(g));
    check("rsv_ready", 32'(RSV_READY), 32'(rr));
    check("busy", 32'(BUSY), 32'(m_busy));
    last_gnt = gi;
    if (gi >= 0) begin
      e.addr = REQ_ADDR[gi*AW +: AW];
      e.data = REQ_DATA[gi*DW +: DW];
      exp_q.push_back(e);
      m_ptr = (gi + 1) % NREQ;
      if (SB) m_busy[e.addr] = 1'b0;
    end
    if (SB && RSV_VALID && rr) m_busy[RSV_ADDR] = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Release reset mid-cycle and follow the 16-step clear sweep.
  task automatic do_sweep();
    m_run  = 1'b0;
    m_ptr  = 0;
    m_busy = '0;
    @(negedge CLK);
    CLR = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge CLK);
      #1;
      check("sweep_cen_n", 32'(RF_CEN_N), 32'd0);
      check("sweep_csel", 32'(RF_CSEL), 32'(e - 1));
      check("init_req_ready", 32'(REQ_READY), 32'd0);
      check("init_rsv_ready", 32'(RSV_READY), 32'd0);
      check("init_done_low", 32'(INIT_DONE), 32'd0);
    end
    @(posedge CLK);
    #1;
    REQ_VALID = '0;
    RSV_VALID = 1'b0;
    check("sweep_end_cen_n", 32'(RF_CEN_N), 32'd1);
    check("init_done", 32'(INIT_DONE), 32'd1);
    m_run = 1'b1;
  endtask

  initial begin
    int exp_seq [6] = '{2, 0, 1, 2, 0, 1};
    CLR       = 1'b1;
    REQ_VALID = 3'b111;
    REQ_ADDR  = '0;
    REQ_DATA  = '0;
    RSV_VALID = 1'b1;
    RSV_ADDR  = 4'd2;
    #2 CLR = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_wen_n", 32'(RF_WEN_N), 32'd1);
    check("rst_wsel", 32'(RF_WSEL), 32'd0);
    check("rst_wdata", RF_WDATA, 32'd0);
    check("rst_cen_n", 32'(RF_CEN_N), 32'd1);
    check("rst_csel", 32'(RF_CSEL), 32'd0);
    check("rst_init_done", 32'(INIT_DONE), 32'd0);
    check("rst_req_ready", 32'(REQ_READY), 32'd0);
    check("rst_rsv_ready", 32'(RSV_READY), 32'd0);
    do_sweep();

    // single write from the load-data requester
    set_req(1, 4'd5, 32'hDEADBEEF);
    REQ_VALID = 3'b010;
    tick();
    REQ_VALID = '0;
    tick();
    tick();

    // all three requesters continuously valid
    set_req(0, 4'd10, 32'h1000_0000);
    set_req(1, 4'd11, 32'h2000_0000);
    set_req(2, 4'd12, 32'h3000_0000);
    REQ_VALID = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_order", 32'(last_gnt), 32'(exp_seq[k]));
      if (last_gnt >= 0)
        set_req(last_gnt, REQ_ADDR[last_gnt*AW +: AW], REQ_DATA[last_gnt*DW +: DW] + 32'd1);
    end
    REQ_VALID = '0;
    tick();
    tick();

    // reserve r3, then try again (WAW stall when scoreboard is built)
    RSV_ADDR  = 4'd3;
    RSV_VALID = 1'b1;
    tick();
    tick();
    check("busy_r3", 32'(BUSY), SB ? 32'h0008 : 32'h0);
    RSV_VALID = 1'b0;
    set_req(0, 4'd3, 32'hA5A5_0003);
    REQ_VALID = 3'b001;
    tick();
    REQ_VALID = '0;
    tick();
    check("busy_cleared", 32'(BUSY), 32'd0);

    // reservation and write of r3 at the same edge
    RSV_VALID = 1'b1;
    set_req(0, 4'd3, 32'h5A5A_0033);
    REQ_VALID = 3'b001;
    tick();
    RSV_VALID = 1'b0;
    REQ_VALID = '0;
    tick();
    check("same_edge_set_wins", 32'(BUSY[3]), 32'(SB));

    // reserve r4..r7, then put a write to r3 in flight and reset
    for (int r = 4; r < 8; r++) begin
      RSV_ADDR  = 4'(r);
      RSV_VALID = 1'b1;
      tick();
    end
    RSV_VALID = 1'b0;
    set_req(0, 4'd3, 32'hCAFE_F00D);
    REQ_VALID = 3'b001;
    tick();
    check("inflight_wen_n", 32'(RF_WEN_N), 32'd0);
    check("busy_pre_reset", 32'(BUSY), SB ? 32'h00F0 : 32'h0);
    CLR = 1'b0;
    #1;
    check("clr_wen_n", 32'(RF_WEN_N), 32'd1);
    check("clr_cen_n", 32'(RF_CEN_N), 32'd1);
    check("clr_busy", 32'(BUSY), 32'd0);
    check("clr_init_done", 32'(INIT_DONE), 32'd0);
    exp_q.delete();
    REQ_VALID = '0;
    do_sweep();

    // reservations across the address range, including a repeat
    begin
      logic [AW-1:0] rsv_list [4] = '{4'd0, 4'd9, 4'd15, 4'd9};
      for (int k = 0; k < 4; k++) begin
        RSV_ADDR  = rsv_list[k];
        RSV_VALID = 1'b1;
        tick();
      end
      RSV_VALID = 1'b0;
    end

    // two requesters, skipping the idle middle slot, random data
    set_req(0, 4'd1, $urandom);
    set_req(2, 4'd14, $urandom);
    REQ_VALID = 3'b101;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_skip", 32'(last_gnt), (k % 2 == 0) ? 32'd0 : 32'd2);
      if (last_gnt >= 0) set_req(last_gnt, REQ_ADDR[last_gnt*AW +: AW], $urandom);
    end
    REQ_VALID = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
